// File: rtl/fu_mem_wb_buffer.sv
// Memory-FU writeback buffer: tracks ops through the fixed memory latency, extracts load
// results, and queues them for a valid/ready writeback port with issue back-pressure.
module fu_mem_wb_buffer #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RD_W    = 5,
  localparam int unsigned IFW    = ($clog2(MEM_LAT + 1) < 2) ? 2 : $clog2(MEM_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_en,
  output logic            issue_ready,
  input  logic            issue_load,
  input  logic [2:0]      issue_bhw,
  input  logic [1:0]      issue_alo,
  input  logic [RD_W-1:0] issue_rd,
  input  logic [31:0]     mem_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic [IFW-1:0]  inflight
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned Last = MEM_LAT - 1;

  logic [MEM_LAT-1:0] pipe_v_q, pipe_v_d, pipe_load_q, pipe_load_d;
  logic [2:0]         pipe_bhw_q [MEM_LAT];
  logic [2:0]         pipe_bhw_d [MEM_LAT];
  logic [1:0]         pipe_alo_q [MEM_LAT];
  logic [1:0]         pipe_alo_d [MEM_LAT];
  logic [RD_W-1:0]    pipe_rd_q  [MEM_LAT];
  logic [RD_W-1:0]    pipe_rd_d  [MEM_LAT];

  logic               ret_v_q, ret_v_d;
  logic [31:0]        ret_data_q, ret_data_d;
  logic [RD_W-1:0]    ret_rd_q, ret_rd_d;

  logic [31:0]        fifo_data_q [DEPTH];
  logic [RD_W-1:0]    fifo_rd_q   [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic               accept, push, pop;
  logic [31:0]        occ;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;

  assign accept = issue_en & issue_ready;

  always_comb begin : pipe_next
    pipe_v_d[0]    = accept;
    pipe_load_d[0] = issue_load;
    pipe_bhw_d[0]  = issue_bhw;
    pipe_alo_d[0]  = issue_alo;
    pipe_rd_d[0]   = issue_rd;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_load_d[i] = pipe_load_q[i-1];
      pipe_bhw_d[i]  = pipe_bhw_q[i-1];
      pipe_alo_d[i]  = pipe_alo_q[i-1];
      pipe_rd_d[i]   = pipe_rd_q[i-1];
    end
  end

  // Stores leave the last stage without producing a result.
  always_comb begin : extract
    lane_b     = mem_data[{pipe_alo_q[Last], 3'b000} +: 8];
    lane_h     = pipe_alo_q[Last][1] ? mem_data[31:16] : mem_data[15:0];
    ret_v_d    = pipe_v_q[Last] & pipe_load_q[Last];
    ret_rd_d   = pipe_rd_q[Last];
    case (pipe_bhw_q[Last])
      3'b000:  ret_data_d = {{24{lane_b[7]}}, lane_b};
      3'b001:  ret_data_d = {{16{lane_h[15]}}, lane_h};
      3'b100:  ret_data_d = {24'h0, lane_b};
      3'b101:  ret_data_d = {16'h0, lane_h};
      default: ret_data_d = mem_data;
    endcase
  end

  // Every load still in flight holds a FIFO slot in reserve.
  always_comb begin : occupancy
    occ      = 32'(cnt_q) + 32'(ret_v_q);
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      occ      = occ + 32'(pipe_v_q[i] & pipe_load_q[i]);
      inflight = inflight + IFW'(pipe_v_q[i]);
    end
    issue_ready = occ < DEPTH;
  end

  assign wb_valid = cnt_q != '0;
  assign wb_data  = fifo_data_q[rd_ptr_q];
  assign wb_rd    = fifo_rd_q[rd_ptr_q];
  assign push     = ret_v_q;
  assign pop      = wb_valid & wb_ready;

  always_comb begin : fifo_next
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v_q    <= '0;
      pipe_load_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_bhw_q[i] <= '0;
        pipe_alo_q[i] <= '0;
        pipe_rd_q[i]  <= '0;
      end
      ret_v_q    <= 1'b0;
      ret_data_q <= '0;
      ret_rd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_rd_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pipe_v_q    <= pipe_v_d;
      pipe_load_q <= pipe_load_d;
      pipe_bhw_q  <= pipe_bhw_d;
      pipe_alo_q  <= pipe_alo_d;
      pipe_rd_q   <= pipe_rd_d;
      ret_v_q     <= ret_v_d;
      ret_data_q  <= ret_data_d;
      ret_rd_q    <= ret_rd_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ret_data_q;
        fifo_rd_q[wr_ptr_q]   <= ret_rd_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A push into a full FIFO without a matching pop would overwrite the head.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (cnt_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_fu_mem_wb_buffer.sv
// Directed self-checking bench for fu_mem_wb_buffer (MEM_LAT=2, DEPTH=2, RD_W=5).
module tb_fu_mem_wb_buffer;
  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_en, issue_ready, issue_load;
  logic [2:0]      issue_bhw;
  logic [1:0]      issue_alo;
  logic [RD_W-1:0] issue_rd;
  logic [31:0]     mem_data;
  logic            wb_valid, wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic [1:0]      inflight;

  int n_cmp = 0;
  int n_err = 0;

  fu_mem_wb_buffer #(.MEM_LAT(2), .DEPTH(2), .RD_W(RD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_ready (issue_ready),
    .issue_load  (issue_load),
    .issue_bhw   (issue_bhw),
    .issue_alo   (issue_alo),
    .issue_rd    (issue_rd),
    .mem_data    (mem_data),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .inflight    (inflight)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic load, input logic [2:0] bhw, input logic [1:0] alo,
                       input logic [RD_W-1:0] rd);
    issue_en   = 1'b1;
    issue_load = load;
    issue_bhw  = bhw;
    issue_alo  = alo;
    issue_rd   = rd;
  endtask

  // One load alone in the machine: result visible three edges after the accepting edge.
  task automatic do_load(input string tag, input logic [2:0] bhw, input logic [1:0] alo,
                         input logic [RD_W-1:0] rd, input logic [31:0] word,
                         input logic [31:0] exp);
    issue(1'b1, bhw, alo, rd);
    tick();
    issue_en = 1'b0;
    mem_data = word;
    tick();
    tick();
    chk({tag, "_notyet"}, {31'h0, wb_valid}, 32'h0);
    tick();
    chk({tag, "_valid"}, {31'h0, wb_valid}, 32'h1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, {27'h0, wb_rd}, {27'h0, rd});
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk({tag, "_drained"}, {31'h0, wb_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; issue_en = 1'b0; issue_load = 1'b0; issue_bhw = 3'b0; issue_alo = 2'b0;
    issue_rd = '0; mem_data = 32'h0; wb_ready = 1'b0;
    #3;
    chk("rst_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_rd", {27'h0, wb_rd}, 32'h0);
    chk("rst_inflight", {30'h0, inflight}, 32'h0);
    #4 rst = 1'b1;
    tick();
    chk("rst_ready", {31'h0, issue_ready}, 32'h1);

    // LW with explicit latency and hold-while-stalled checks
    issue(1'b1, 3'b010, 2'd0, 5'd7);
    tick();
    issue_en = 1'b0;
    mem_data = 32'hDEADBEEF;
    chk("lw_inflight1", {30'h0, inflight}, 32'h1);
    tick();
    chk("lw_inflight2", {30'h0, inflight}, 32'h1);
    chk("lw_t1_valid", {31'h0, wb_valid}, 32'h0);
    tick();
    chk("lw_t2_valid", {31'h0, wb_valid}, 32'h0);
    chk("lw_t2_inflight", {30'h0, inflight}, 32'h0);
    tick();
    chk("lw_valid", {31'h0, wb_valid}, 32'h1);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", {27'h0, wb_rd}, 32'd7);
    mem_data = 32'h0;
    tick();
    chk("lw_hold_valid", {31'h0, wb_valid}, 32'h1);
    chk("lw_hold_data", wb_data, 32'hDEADBEEF);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("lw_popped", {31'h0, wb_valid}, 32'h0);

    // Extraction
    do_load("lh_a2", 3'b001, 2'd2, 5'd10, 32'h80FF1234, 32'hFFFF80FF);
    do_load("lhu_a1", 3'b101, 2'd1, 5'd11, 32'h80FF1234, 32'h00001234);
    do_load("lb_a0", 3'b000, 2'd0, 5'd12, 32'h80FF1234, 32'h00000034);
    do_load("lbu_a2", 3'b100, 2'd2, 5'd13, 32'h80FF8234, 32'h000000FF);

    // Back-pressure: two loads fill the reservation, a third request is ignored
    issue(1'b1, 3'b010, 2'd0, 5'd1);
    tick();
    chk("bp_ready_after1", {31'h0, issue_ready}, 32'h1);
    issue(1'b1, 3'b010, 2'd0, 5'd2);
    tick();
    chk("bp_ready_after2", {31'h0, issue_ready}, 32'h0);
    issue(1'b1, 3'b010, 2'd0, 5'd3);
    mem_data = 32'h11111111;
    tick();
    mem_data = 32'h22222222;
    tick();
    tick();
    tick();
    chk("bp_ready_full", {31'h0, issue_ready}, 32'h0);
    chk("bp_inflight", {30'h0, inflight}, 32'h0);
    chk("bp_head_data", wb_data, 32'h11111111);
    chk("bp_head_rd", {27'h0, wb_rd}, 32'd1);
    issue_en = 1'b0;
    wb_ready = 1'b1;
    tick();
    chk("bp_second_data", wb_data, 32'h22222222);
    chk("bp_second_rd", {27'h0, wb_rd}, 32'd2);
    tick();
    wb_ready = 1'b0;
    chk("bp_empty", {31'h0, wb_valid}, 32'h0);
    chk("bp_ready_back", {31'h0, issue_ready}, 32'h1);

    // Stores: never reach writeback, never block issue
    issue(1'b0, 3'b010, 2'd0, 5'd9);
    tick();
    chk("st_ready1", {31'h0, issue_ready}, 32'h1);
    issue(1'b0, 3'b010, 2'd0, 5'd9);
    tick();
    issue_en = 1'b0;
    chk("st_ready2", {31'h0, issue_ready}, 32'h1);
    chk("st_inflight", {30'h0, inflight}, 32'h2);
    tick();
    tick();
    tick();
    tick();
    chk("st_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("st_ready_end", {31'h0, issue_ready}, 32'h1);

    // Streaming with wb_ready high: push and pop on the same edge
    wb_ready = 1'b1;
    mem_data = 32'h80FF1234;
    issue(1'b1, 3'b000, 2'd3, 5'd4);
    tick();
    issue(1'b1, 3'b100, 2'd3, 5'd5);
    tick();
    issue_en = 1'b0;
    chk("pp_ready_low", {31'h0, issue_ready}, 32'h0);
    tick();
    tick();
    chk("pp_first_data", wb_data, 32'hFFFFFF80);
    chk("pp_first_rd", {27'h0, wb_rd}, 32'd4);
    tick();
    chk("pp_second_valid", {31'h0, wb_valid}, 32'h1);
    chk("pp_second_data", wb_data, 32'h00000080);
    chk("pp_second_rd", {27'h0, wb_rd}, 32'd5);
    tick();
    chk("pp_empty", {31'h0, wb_valid}, 32'h0);
    chk("pp_ready_back", {31'h0, issue_ready}, 32'h1);
    wb_ready = 1'b0;

    // Reset mid-operation discards queued and in-flight work asynchronously
    issue(1'b1, 3'b010, 2'd0, 5'd6);
    tick();
    issue_en = 1'b0;
    mem_data = 32'hAAAA5555;
    tick();
    tick();
    tick();
    chk("mr_queued", {31'h0, wb_valid}, 32'h1);
    issue(1'b1, 3'b010, 2'd0, 5'd8);
    tick();
    issue_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_async_valid", {31'h0, wb_valid}, 32'h0);
    chk("mr_async_data", wb_data, 32'h0);
    chk("mr_async_rd", {27'h0, wb_rd}, 32'h0);
    chk("mr_async_inflight", {30'h0, inflight}, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mr_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("mr_ready", {31'h0, issue_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
